// File: rtl/timer_controller.sv
// timer_controller: keypad M:SS preset capture and cook/pause/done sequencer for the min:sec countdown counter.
// Latency: state and buffer update at the edge after an input is sampled; outputs decode the state register (cnt_enable also gates door_closed).
// Backpressure: none; a key_valid strobe is accepted or dropped in its own cycle. Define TIMER_CTRL_BEEP_EN to build the timed beep in DONE.
module timer_controller #(
   parameter int TICK_DIV  = 100,
   parameter int BEEP_SECS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       start,
   input  logic       stop_clear,
   input  logic       door_closed,
   input  logic       count_zero,
   output logic [3:0] preset_us,
   output logic [3:0] preset_ds,
   output logic [3:0] preset_m,
   output logic       cnt_load,
   output logic       cnt_enable,
   output logic       mag_on,
   output logic       beep,
   output logic [2:0] state
);

   localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SET   = 3'd1,
      LOAD  = 3'd2,
      COOK  = 3'd3,
      PAUSE = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t        cur_state;
   state_t        nxt_state;
   logic [3:0]    buf_m;
   logic [3:0]    buf_ds;
   logic [3:0]    buf_us;
   logic [PW-1:0] presc;
   logic          tick;
   logic          key_acc;
   logic          key_gives_zero;
   logic          buf_zero;
   logic          buf_clr;
   logic          buf_shift;
   logic          done_exit;

   // A key is only taken in IDLE/SET, must be BCD, and the digit moving into the tens slot must stay <= 5.
   assign key_acc        = key_valid && (key_digit <= 4'd9) && (buf_us <= 4'd5) &&
                           ((cur_state == IDLE) || (cur_state == SET));
   assign key_gives_zero = (buf_ds == 4'd0) && (buf_us == 4'd0) && (key_digit == 4'd0);
   assign buf_zero       = (buf_m == 4'd0) && (buf_ds == 4'd0) && (buf_us == 4'd0);

   // Tick fires on the last count of the cook prescaler.
   assign tick = (cur_state == COOK) && (presc == PRESC_LAST);

`ifdef TIMER_CTRL_BEEP_EN
   localparam int            SW        = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
   localparam logic [SW-1:0] SECS_LAST = SW'(BEEP_SECS - 1);

   logic [PW-1:0] beep_presc;
   logic [SW-1:0] beep_secs;

   assign done_exit = (cur_state == DONE) && (beep_presc == PRESC_LAST) && (beep_secs == SECS_LAST);
   assign beep      = (cur_state == DONE);

   // Beep timer: own prescaler plus seconds count, held at zero outside DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beep_presc <= '0;
         beep_secs  <= '0;
      end else if (cur_state == DONE) begin
         if (beep_presc == PRESC_LAST) begin
            beep_presc <= '0;
            beep_secs  <= beep_secs + 1'b1;
         end else begin
            beep_presc <= beep_presc + 1'b1;
         end
      end else begin
         beep_presc <= '0;
         beep_secs  <= '0;
      end
   end
`else
   // Without the beep, DONE is a single-cycle pass-through back to IDLE.
   assign done_exit = (cur_state == DONE);
   assign beep      = 1'b0;
`endif

   // Next-state and buffer control; priority is stop_clear, then door, then start, then key.
   always_comb begin
      nxt_state = cur_state;
      buf_clr   = 1'b0;
      buf_shift = 1'b0;
      case (cur_state)
         IDLE: begin
            if (stop_clear) begin
               buf_clr = 1'b1;
            end else if (key_acc) begin
               buf_shift = 1'b1;
               if (!key_gives_zero) nxt_state = SET;
            end
         end
         SET: begin
            if (stop_clear) begin
               nxt_state = IDLE;
               buf_clr   = 1'b1;
            end else if (start && door_closed && !buf_zero) begin
               nxt_state = LOAD;
            end else if (key_acc) begin
               // Shifting zeros can empty the buffer again; an empty buffer is never startable.
               buf_shift = 1'b1;
               nxt_state = key_gives_zero ? IDLE : SET;
            end
         end
         LOAD: begin
            nxt_state = COOK;
         end
         COOK: begin
            if (stop_clear || !door_closed) nxt_state = PAUSE;
            else if (count_zero)            nxt_state = DONE;
         end
         PAUSE: begin
            if (stop_clear) begin
               nxt_state = IDLE;
               buf_clr   = 1'b1;
            end else if (start && door_closed) begin
               nxt_state = COOK;
            end
         end
         DONE: begin
            if (stop_clear || !door_closed || done_exit) begin
               nxt_state = IDLE;
               buf_clr   = 1'b1;
            end
         end
         default: begin
            nxt_state = IDLE;
            buf_clr   = 1'b1;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur_state <= IDLE;
      else       cur_state <= nxt_state;
   end

   // Preset buffer: shift-left digit entry, cleared on the stop/done paths.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_m  <= 4'd0;
         buf_ds <= 4'd0;
         buf_us <= 4'd0;
      end else if (buf_clr) begin
         buf_m  <= 4'd0;
         buf_ds <= 4'd0;
         buf_us <= 4'd0;
      end else if (buf_shift) begin
         buf_m  <= buf_ds;
         buf_ds <= buf_us;
         buf_us <= key_digit;
      end
   end

   // Cook prescaler: free-runs only in COOK so a resumed cook waits a full second.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  presc <= '0;
      else if (cur_state == COOK) presc <= tick ? '0 : presc + 1'b1;
      else                        presc <= '0;
   end

   assign preset_m   = buf_m;
   assign preset_ds  = buf_ds;
   assign preset_us  = buf_us;
   assign cnt_load   = (cur_state == LOAD);
   assign cnt_enable = tick && door_closed;
   assign mag_on     = (cur_state == COOK);
   assign state      = cur_state;

endmodule

// File: tb/tb_timer_controller.sv
// tb_timer_controller: self-checking bench for timer_controller with TICK_DIV=4, BEEP_SECS=3.
// Latency: inputs driven 2 time units after a rising edge, outputs checked in the same cycle before the next edge.
// Backpressure: not applicable; expected counter loads are queued at start and popped when cnt_load is seen.
module tb_timer_controller;

   localparam int TICK_DIV  = 4;
   localparam int BEEP_SECS = 3;

   logic       clk         = 1'b0;
   logic       reset       = 1'b1;
   logic       key_valid   = 1'b0;
   logic [3:0] key_digit   = 4'd0;
   logic       start       = 1'b0;
   logic       stop_clear  = 1'b0;
   logic       door_closed = 1'b1;
   logic       count_zero  = 1'b0;
   logic [3:0] preset_us;
   logic [3:0] preset_ds;
   logic [3:0] preset_m;
   logic       cnt_load;
   logic       cnt_enable;
   logic       mag_on;
   logic       beep;
   logic [2:0] state;

   int         n_tests    = 0;
   int         n_fail     = 0;
   int         loads_seen = 0;
   logic [11:0] load_q[$];

   // Reference model of the preset buffer.
   logic [3:0] m_m  = 4'd0;
   logic [3:0] m_ds = 4'd0;
   logic [3:0] m_us = 4'd0;

   always #5 clk = ~clk;

   timer_controller #(
      .TICK_DIV  (TICK_DIV),
      .BEEP_SECS (BEEP_SECS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_valid   (key_valid),
      .key_digit   (key_digit),
      .start       (start),
      .stop_clear  (stop_clear),
      .door_closed (door_closed),
      .count_zero  (count_zero),
      .preset_us   (preset_us),
      .preset_ds   (preset_ds),
      .preset_m    (preset_m),
      .cnt_load    (cnt_load),
      .cnt_enable  (cnt_enable),
      .mag_on      (mag_on),
      .beep        (beep),
      .state       (state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check_buf(input string tag);
      check(tag, {preset_m, preset_ds, preset_us}, {m_m, m_ds, m_us});
   endtask

   // Key press from IDLE/SET: model the shift/reject rules, then compare buffer and state.
   task automatic press(input logic [3:0] d);
      key_valid = 1'b1;
      key_digit = d;
      if (d <= 4'd9 && m_us <= 4'd5) begin
         m_m  = m_ds;
         m_ds = m_us;
         m_us = d;
      end
      step();
      key_valid = 1'b0;
      check_buf("key_buf");
      check("key_state", state, ({m_m, m_ds, m_us} != 12'd0) ? 3'd1 : 3'd0);
   endtask

   task automatic clear_buf();
      stop_clear = 1'b1;
      step();
      stop_clear = 1'b0;
      m_m = 4'd0; m_ds = 4'd0; m_us = 4'd0;
      check("clr_state", state, 3'd0);
      check_buf("clr_buf");
   endtask

   // From SET: start, expect one LOAD cycle, then COOK at prescaler count 0.
   task automatic start_cook();
      start = 1'b1;
      load_q.push_back({m_m, m_ds, m_us});
      step();
      check("load_state", state, 3'd2);
      check("load_pulse", cnt_load, 1'b1);
      check("load_mag", mag_on, 1'b0);
      start = 1'b0;
      step();
      check("cook_state", state, 3'd3);
      check("cook_load_low", cnt_load, 1'b0);
   endtask

   // n COOK cycles starting at prescaler phase k0; enable is expected on every 4th.
   task automatic cook_check(input int n, input int k0);
      for (int i = 0; i < n; i++) begin
         check("cook_en", cnt_enable, ((k0 + i) % TICK_DIV) == (TICK_DIV - 1));
         check("cook_mag", mag_on, 1'b1);
         check("cook_st", state, 3'd3);
         step();
      end
   endtask

   // Scoreboard side: every cnt_load must match a queued preset.
   always @(negedge clk) begin
      if (cnt_load === 1'b1) begin
         loads_seen++;
         check("load_queued", load_q.size() != 0, 1'b1);
         if (load_q.size() != 0)
            check("load_preset", {preset_m, preset_ds, preset_us}, load_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #3;
      check("rst_state", state, 3'd0);
      check("rst_buf", {preset_m, preset_ds, preset_us}, 12'h000);
      check("rst_load", cnt_load, 1'b0);
      check("rst_en", cnt_enable, 1'b0);
      check("rst_mag", mag_on, 1'b0);
      check("rst_beep", beep, 1'b0);
      step();
      reset = 1'b0;
      step();

      // Key entry, reject of ds>5 and non-BCD digit
      press(4'd1);
      press(4'd6);
      press(4'd0);
      press(4'd12);
      check("t1_buf016", {preset_m, preset_ds, preset_us}, 12'h016);

      // Full cook to DONE
      clear_buf();
      press(4'd0);
      press(4'd2);
      start_cook();
      cook_check(8, 0);
      count_zero = 1'b1;
      step();
      count_zero = 1'b0;
      check("done_state", state, 3'd5);
      check("done_mag", mag_on, 1'b0);
      check("done_en", cnt_enable, 1'b0);
`ifdef TIMER_CTRL_BEEP_EN
      for (int i = 0; i < BEEP_SECS * TICK_DIV; i++) begin
         check("beep_state", state, 3'd5);
         check("beep_on", beep, 1'b1);
         step();
      end
`else
      check("beep_off", beep, 1'b0);
      step();
`endif
      check("done_exit", state, 3'd0);
      check("done_beep_low", beep, 1'b0);
      m_m = 4'd0; m_ds = 4'd0; m_us = 4'd0;
      check_buf("done_buf_clr");

      // Door-open pause and resume without reload
      press(4'd5);
      start_cook();
      cook_check(2, 0);
      key_valid = 1'b1;
      key_digit = 4'd7;
      cook_check(1, 2);
      key_valid = 1'b0;
      check_buf("cook_key_ignored");
      door_closed = 1'b0;
      #1;
      check("door_gates_en", cnt_enable, 1'b0);
      check("door_still_cook", state, 3'd3);
      step();
      check("pause_state", state, 3'd4);
      check("pause_mag", mag_on, 1'b0);
      check("pause_en", cnt_enable, 1'b0);
      start = 1'b1;
      step();
      check("pause_door_open", state, 3'd4);
      door_closed = 1'b1;
      step();
      start = 1'b0;
      check("resume_state", state, 3'd3);
      check("resume_no_load", cnt_load, 1'b0);
      cook_check(4, 0);
      check_buf("cook_buf_kept");
      stop_clear = 1'b1;
      step();
      check("stop_pause", state, 3'd4);
      check_buf("pause_buf_kept");
      step();
      stop_clear = 1'b0;
      m_m = 4'd0; m_ds = 4'd0; m_us = 4'd0;
      check("stop_idle", state, 3'd0);
      check_buf("stop_buf_clr");

      // start and stop_clear together in SET
      press(4'd3);
      start = 1'b1;
      stop_clear = 1'b1;
      step();
      start = 1'b0;
      stop_clear = 1'b0;
      m_m = 4'd0; m_ds = 4'd0; m_us = 4'd0;
      check("ss_state", state, 3'd0);
      check_buf("ss_buf");

      // Empty buffer cannot start
      start = 1'b1;
      step();
      step();
      start = 1'b0;
      check("zero_nostart", state, 3'd0);

      // Asynchronous reset in the middle of a COOK cycle
      press(4'd4);
      start_cook();
      cook_check(3, 0);
      check("pre_rst_en", cnt_enable, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_state", state, 3'd0);
      check("arst_mag", mag_on, 1'b0);
      check("arst_en", cnt_enable, 1'b0);
      check("arst_buf", {preset_m, preset_ds, preset_us}, 12'h000);
      step();
      reset = 1'b0;
      m_m = 4'd0; m_ds = 4'd0; m_us = 4'd0;
      step();
      check("post_rst_state", state, 3'd0);

      check("load_q_empty", load_q.size(), 0);
      check("loads_seen", loads_seen, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
